// File: rtl/genaxis_pkg.sv
// Shared types and widths for the AXI-Stream packet former.
package genaxis_pkg;

    localparam int LEN_W   = 16;
    localparam int PAUSE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SEND  = 2'd2,
        ST_PAUSE = 2'd3
    } genaxis_former_state_t;

endpackage

// File: rtl/genaxis_clamp.sv
// Combinational range clamp. An inverted range (min > max) resolves to min.
module genaxis_clamp #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] min_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] result
);

    // Lower bound wins when the range is inverted.
    always_comb begin
        if ((min_val > max_val) || (value < min_val)) begin
            result = min_val;
        end else if (value > max_val) begin
            result = max_val;
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/genaxis_packet_former.sv
// AXI-Stream packet former: turns the random generator's per-cycle length,
// channel, data and pause into clamped, well-formed packets with idle gaps.
// Optional statistics counters are built when GENAXIS_FORMER_STAT_EN is defined;
// otherwise the stat ports read 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stream quiet, waiting for cntrl_en_i
// LOAD     | capture clamped length/channel/pause and first data word
// SEND     | present beats; tlast on the final one
// PAUSE    | count down the inter-packet idle gap
module genaxis_packet_former
    import genaxis_pkg::*;
#(
    parameter int ID_WIDTH   = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cntrl_en_i,
    input  logic [LEN_W-1:0]      cntrl_min_length_i,
    input  logic [LEN_W-1:0]      cntrl_max_length_i,
    input  logic [ID_WIDTH-1:0]   cntrl_min_channel_i,
    input  logic [ID_WIDTH-1:0]   cntrl_max_channel_i,
    input  logic [PAUSE_W-1:0]    cntrl_min_pause_i,
    input  logic [PAUSE_W-1:0]    cntrl_max_pause_i,
    input  logic [LEN_W-1:0]      pkt_length_i,
    input  logic [ID_WIDTH-1:0]   pkt_channel_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    input  logic [PAUSE_W-1:0]    pkt_pause_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [ID_WIDTH-1:0]   m_axis_tid_o,
    output logic                  m_axis_tlast_o,
    output logic                  busy_o,
    output logic [31:0]           stat_pkt_cnt_o,
    output logic [31:0]           stat_beat_cnt_o
);

    genaxis_former_state_t state;

    logic [LEN_W-1:0]    len_clamped;
    logic [LEN_W-1:0]    len_fixed;
    logic [ID_WIDTH-1:0] ch_clamped;
    logic [PAUSE_W-1:0]  pause_clamped;
    logic [LEN_W-1:0]    remaining;
    logic [PAUSE_W-1:0]  pause_cnt;
    logic                handshake;

    genaxis_clamp #(.W(LEN_W)) u_clamp_len (
        .value   (pkt_length_i),
        .min_val (cntrl_min_length_i),
        .max_val (cntrl_max_length_i),
        .result  (len_clamped)
    );

    genaxis_clamp #(.W(ID_WIDTH)) u_clamp_ch (
        .value   (pkt_channel_i),
        .min_val (cntrl_min_channel_i),
        .max_val (cntrl_max_channel_i),
        .result  (ch_clamped)
    );

    genaxis_clamp #(.W(PAUSE_W)) u_clamp_pause (
        .value   (pkt_pause_i),
        .min_val (cntrl_min_pause_i),
        .max_val (cntrl_max_pause_i),
        .result  (pause_clamped)
    );

    // A zero-beat packet is not expressible on AXIS, so it becomes one beat.
    assign len_fixed = (len_clamped == '0) ? LEN_W'(1) : len_clamped;
    assign handshake = m_axis_tvalid_o && m_axis_tready_i;

    // Sequencer with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tdata_o  <= '0;
            m_axis_tid_o    <= '0;
            busy_o          <= 1'b0;
            remaining       <= '0;
            pause_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cntrl_en_i) begin
                        state  <= ST_LOAD;
                        busy_o <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    remaining       <= len_fixed;
                    m_axis_tid_o    <= ch_clamped;
                    pause_cnt       <= pause_clamped;
                    m_axis_tdata_o  <= pkt_data_i;
                    m_axis_tvalid_o <= 1'b1;
                    m_axis_tlast_o  <= (len_fixed == LEN_W'(1));
                    state           <= ST_SEND;
                end
                ST_SEND: begin
                    if (m_axis_tready_i) begin
                        m_axis_tdata_o <= pkt_data_i;
                        remaining      <= remaining - LEN_W'(1);
                        m_axis_tlast_o <= (remaining == LEN_W'(2));
                        if (m_axis_tlast_o) begin
                            m_axis_tvalid_o <= 1'b0;
                            m_axis_tlast_o  <= 1'b0;
                            if (pause_cnt != '0) begin
                                state <= ST_PAUSE;
                            end else if (cntrl_en_i) begin
                                state <= ST_LOAD;
                            end else begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    pause_cnt <= pause_cnt - PAUSE_W'(1);
                    if (pause_cnt == PAUSE_W'(1)) begin
                        if (cntrl_en_i) begin
                            state <= ST_LOAD;
                        end else begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    m_axis_tvalid_o <= 1'b0;
                    m_axis_tlast_o  <= 1'b0;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

`ifdef GENAXIS_FORMER_STAT_EN
    logic [31:0] pkt_cnt;
    logic [31:0] beat_cnt;

    // Packet and beat counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (handshake) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (m_axis_tlast_o) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt_o  = pkt_cnt;
    assign stat_beat_cnt_o = beat_cnt;
`else
    assign stat_pkt_cnt_o  = '0;
    assign stat_beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_genaxis_packet_former.sv
// Directed self-checking bench for genaxis_packet_former.
module tb_genaxis_packet_former;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] min_len = 16'd4, max_len = 16'd4;
    logic [9:0]  min_ch = 10'd0, max_ch = 10'd0;
    logic [31:0] min_p = 32'd0, max_p = 32'd0;
    logic [15:0] pkt_len = 16'd4;
    logic [9:0]  pkt_ch = 10'd0;
    logic [31:0] pkt_data = 32'd0;
    logic [31:0] pkt_pause = 32'd0;
    logic        tready = 1'b1;
    logic        tvalid, tlast, busy;
    logic [31:0] tdata;
    logic [9:0]  tid;
    logic [31:0] stat_pkt, stat_beat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    genaxis_packet_former #(.ID_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cntrl_en_i          (en),
        .cntrl_min_length_i  (min_len),
        .cntrl_max_length_i  (max_len),
        .cntrl_min_channel_i (min_ch),
        .cntrl_max_channel_i (max_ch),
        .cntrl_min_pause_i   (min_p),
        .cntrl_max_pause_i   (max_p),
        .pkt_length_i        (pkt_len),
        .pkt_channel_i       (pkt_ch),
        .pkt_data_i          (pkt_data),
        .pkt_pause_i         (pkt_pause),
        .m_axis_tvalid_o     (tvalid),
        .m_axis_tready_i     (tready),
        .m_axis_tdata_o      (tdata),
        .m_axis_tid_o        (tid),
        .m_axis_tlast_o      (tlast),
        .busy_o              (busy),
        .stat_pkt_cnt_o      (stat_pkt),
        .stat_beat_cnt_o     (stat_beat)
    );

    function automatic int unsigned clamp_ref(int unsigned v, int unsigned lo, int unsigned hi);
        if (lo > hi) return lo;
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Observes one packet at negedges: idle gap before it, beats, field stability,
    // tdata freshness, tid range. Drives tready (and random fields when rnd=1).
    task automatic capture(input bit rnd, input int unsigned lo, input int unsigned hi,
                           input int drop_at, output int beats, output int gap,
                           output int busy_gap, output int unsigned first_len,
                           output bit tid_ok, output bit stable_ok, output bit data_ok,
                           output bit timeout);
        logic [31:0] prev_data, prev_tdata;
        logic [15:0] prev_len;
        logic [9:0]  prev_tid, pkt_tid;
        logic        prev_tlast, prev_tvalid, prev_hs, hs, started, done;
        int n;
        beats = 0; gap = 0; busy_gap = 0; first_len = 0;
        tid_ok = 1; stable_ok = 1; data_ok = 1; timeout = 0;
        prev_data = pkt_data; prev_len = pkt_len; prev_tdata = '0; prev_tid = '0;
        prev_tlast = 0; prev_tvalid = 0; prev_hs = 0; started = 0; done = 0; pkt_tid = '0;
        n = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                timeout = 1;
                break;
            end
            if (rnd) begin
                tready  = 1'($urandom_range(0, 1));
                pkt_len = 16'($urandom_range(0, 40));
                pkt_ch  = 10'($urandom_range(0, 1023));
            end else begin
                tready = 1'b1;
            end
            pkt_data = $urandom;
            if (!started) begin
                if (tvalid) begin
                    started   = 1;
                    first_len = int'(prev_len);
                    pkt_tid   = tid;
                end else begin
                    gap++;
                    if (busy) busy_gap++;
                end
            end
            if (started) begin
                if (!tvalid) begin
                    stable_ok = 0;
                    break;
                end
                if (tid != pkt_tid || tid < lo || tid > hi) tid_ok = 0;
                if (prev_tvalid && !prev_hs) begin
                    if (tdata !== prev_tdata || tlast !== prev_tlast || tid !== prev_tid)
                        stable_ok = 0;
                end else if (tdata !== prev_data) begin
                    data_ok = 0;
                end
                hs = tvalid && tready;
                if (hs) begin
                    beats++;
                    if (beats == drop_at) en = 1'b0;
                    if (tlast) done = 1;
                end
                prev_hs = hs;
            end
            prev_tvalid = tvalid;
            prev_tdata  = tdata;
            prev_tlast  = tlast;
            prev_tid    = tid;
            prev_data   = pkt_data;
            prev_len    = pkt_len;
        end
    endtask

    task automatic wait_idle();
        en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tready = 1'b1;
            if (!busy && !tvalid) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tvalid, tlast, busy} !== 3'b000 || tdata !== 32'd0 || tid !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b last=%0b busy=%0b data=%h tid=%0d required all 0",
                     tvalid, tlast, busy, tdata, tid);
        end
        checks++;
        if (stat_pkt !== 32'd0 || stat_beat !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: pkt=%0d beat=%0d required 0/0", stat_pkt, stat_beat);
        end
        en = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_en: busy=%0b valid=%0b required 0/0", busy, tvalid);
        end
    endtask

    task automatic test_fixed_len();
        int beats, gap, bgap; int unsigned fl; bit tok, sok, dok, to;
        min_len = 16'd4; max_len = 16'd4; pkt_len = 16'd9;
        min_ch = 10'd2; max_ch = 10'd5; pkt_ch = 10'd1;
        min_p = 32'd0; max_p = 32'd0; pkt_pause = 32'd7;
        en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
            checks++;
            if (to || beats != 4) begin
                errors++;
                $display("FAIL fixed_beats[%0d]: got %0d required 4 (timeout=%0b)", p, beats, to);
            end
            checks++;
            if (gap != 1) begin
                errors++;
                $display("FAIL fixed_gap[%0d]: got %0d idle cycles required 1", p, gap);
            end
            checks++;
            if (!tok || !sok || !dok) begin
                errors++;
                $display("FAIL fixed_fields[%0d]: tid_ok=%0b stable_ok=%0b data_ok=%0b required 1/1/1",
                         p, tok, sok, dok);
            end
        end
    endtask

    task automatic test_clamp();
        int beats, gap, bgap; int unsigned fl; bit tok, sok, dok, to;
        logic [15:0] lo_t [4] = '{16'd8, 16'd8, 16'd20, 16'd0};
        logic [15:0] hi_t [4] = '{16'd16, 16'd16, 16'd10, 16'd5};
        logic [15:0] v_t  [4] = '{16'd100, 16'd2, 16'd15, 16'd0};
        int          exp_t[4] = '{16, 8, 20, 1};
        for (int k = 0; k < 4; k++) begin
            min_len = lo_t[k]; max_len = hi_t[k]; pkt_len = v_t[k];
            capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
            checks++;
            if (to || beats != exp_t[k]) begin
                errors++;
                $display("FAIL clamp_len[%0d]: got %0d beats required %0d", k, beats, exp_t[k]);
            end
            checks++;
            if (gap != 1 || !sok || !dok) begin
                errors++;
                $display("FAIL clamp_stream[%0d]: gap=%0d stable=%0b data=%0b required 1/1/1",
                         k, gap, sok, dok);
            end
        end
    endtask

    task automatic test_pause();
        int beats, gap, bgap; int unsigned fl; bit tok, sok, dok, to;
        min_len = 16'd4; max_len = 16'd4; pkt_len = 16'd4;
        min_p = 32'd0; max_p = 32'd3; pkt_pause = 32'd5;
        capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        checks++;
        if (to || gap != 4 || bgap != 4) begin
            errors++;
            $display("FAIL pause_3: gap=%0d busy_gap=%0d required 4/4", gap, bgap);
        end
        min_p = 32'd2; max_p = 32'd1; pkt_pause = 32'd0;
        capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        capture(0, 2, 2, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        checks++;
        if (to || gap != 3 || beats != 4) begin
            errors++;
            $display("FAIL pause_inverted: gap=%0d beats=%0d required 3/4", gap, beats);
        end
        min_p = 32'd0; max_p = 32'd0;
    endtask

    task automatic test_random_ready();
        int beats, gap, bgap; int unsigned fl, exp_len; bit tok, sok, dok, to;
        min_len = 16'd3; max_len = 16'd6;
        min_ch = 10'd100; max_ch = 10'd200;
        capture(1, 0, 1023, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        for (int p = 0; p < 6; p++) begin
            capture(1, 100, 200, 0, beats, gap, bgap, fl, tok, sok, dok, to);
            exp_len = clamp_ref(fl, 3, 6);
            checks++;
            if (to || beats != int'(exp_len)) begin
                errors++;
                $display("FAIL rand_beats[%0d]: got %0d required %0d (len_in=%0d)", p, beats, exp_len, fl);
            end
            checks++;
            if (!tok || !sok || !dok || gap != 1) begin
                errors++;
                $display("FAIL rand_fields[%0d]: tid_ok=%0b stable=%0b data=%0b gap=%0d required 1/1/1/1",
                         p, tok, sok, dok, gap);
            end
        end
        tready = 1'b1;
    endtask

    task automatic test_en_drop();
        int beats, gap, bgap; int unsigned fl; bit tok, sok, dok, to;
        logic [2:0] busy_seq;
        wait_idle();
        min_len = 16'd8; max_len = 16'd8; pkt_len = 16'd1;
        min_ch = 10'd0; max_ch = 10'd1023; pkt_ch = 10'd77;
        min_p = 32'd2; max_p = 32'd2; pkt_pause = 32'd0;
        en = 1'b1;
        capture(0, 77, 77, 2, beats, gap, bgap, fl, tok, sok, dok, to);
        checks++;
        if (to || beats != 8 || !tok) begin
            errors++;
            $display("FAIL en_drop_beats: got %0d tid_ok=%0b required 8/1", beats, tok);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            busy_seq[2-i] = busy;
        end
        checks++;
        if (busy_seq !== 3'b110) begin
            errors++;
            $display("FAIL en_drop_pause: busy sequence %b required 110", busy_seq);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle: busy=%0b valid=%0b required 0/0", busy, tvalid);
        end
    endtask

    task automatic test_reset_mid();
        int beats, gap, bgap, hs_cnt; int unsigned fl; bit tok, sok, dok, to;
        min_p = 32'd0; max_p = 32'd0;
        en = 1'b1;
        hs_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tready = 1'b1;
            if (tvalid && tready) hs_cnt++;
            if (hs_cnt == 3) begin
                reset = 1'b1;
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (hs_cnt != 3 || tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0 || tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: beats_seen=%0d valid=%0b last=%0b busy=%0b data=%h required 3/0/0/0/0",
                     hs_cnt, tvalid, tlast, busy, tdata);
        end
        reset = 1'b0;
        capture(0, 77, 77, 0, beats, gap, bgap, fl, tok, sok, dok, to);
        checks++;
        if (to || beats != 8 || gap != 1 || !dok) begin
            errors++;
            $display("FAIL reset_restart: beats=%0d gap=%0d data_ok=%0b required 8/1/1", beats, gap, dok);
        end
    endtask

    task automatic test_stats();
        int beats, gap, bgap, bad; int unsigned fl; bit tok, sok, dok, to;
        logic [31:0] exp_pkt, exp_beat;
`ifdef GENAXIS_FORMER_STAT_EN
        exp_pkt = 32'd10; exp_beat = 32'd40;
`else
        exp_pkt = 32'd0; exp_beat = 32'd0;
`endif
        en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        min_len = 16'd4; max_len = 16'd4; pkt_len = 16'd4;
        en = 1'b1;
        bad = 0;
        for (int p = 0; p < 10; p++) begin
            capture(0, 0, 1023, (p == 9) ? 4 : 0, beats, gap, bgap, fl, tok, sok, dok, to);
            if (to || beats != 4) bad++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bad != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stats_traffic: bad_packets=%0d busy=%0b required 0/0", bad, busy);
        end
        checks++;
        if (stat_pkt !== exp_pkt || stat_beat !== exp_beat) begin
            errors++;
            $display("FAIL stats_counts: pkt=%0d beat=%0d required %0d/%0d",
                     stat_pkt, stat_beat, exp_pkt, exp_beat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed_len();
        test_clamp();
        test_pause();
        test_random_ready();
        test_en_drop();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
